d3_run_ctrl: RTL and testbench
==============================

# d3_run_ctrl

Run controller for the day-3 solver. On a `start` pulse it soft-resets the solver, then streams `byte_count` bytes from a 1-cycle-latency input memory into the solver's byte port at up to one byte per cycle. It waits a fixed drain period, pulses `read_val_done`, and captures the solver's 64-bit total into a held result register. It sits between the host/testbench input memory and the solver.

## Interface
- `ADDR_W`, 16, input memory address width
- `DRAIN_CYCLES`, 4, idle cycles after the last byte before `read_val_done`; must be ≥1
- `TIMEOUT_CYCLES`, 1024, maximum wait for solver result after `read_val_done`
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run request pulse; sampled only in IDLE
- `byte_count`  in  ADDR_W+1  bytes to stream, sampled with `start`; 0 is legal
- `pause`  in  1  stalls new memory reads while high
- `busy`  out  1  high in every state except IDLE
- `mem_rd_en`  out  1  memory read strobe
- `mem_addr`  out  ADDR_W  read address
- `mem_rd_data`  in  8  read data, valid the cycle after `mem_rd_en`
- `slv_rst_n`  out  1  solver synchronous reset, active-low
- `slv_read_val`  out  8  byte to solver
- `slv_read_val_valid`  out  1  byte qualifier
- `slv_read_val_done`  out  1  end-of-input pulse
- `slv_output_data`  in  64  solver total
- `slv_output_data_valid`  in  1  solver total valid
- `result`  out  64  captured total, held until next accepted `start`
- `result_valid`  out  1  high from capture until next accepted `start`
- `error`  out  1  timeout flag, same lifetime as `result_valid`

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE, WAIT, plus ERROR when timeout is enabled.
- IDLE: on `start`, latch `byte_count`, clear `result`, `result_valid` and `error`, then go to CLEAR.
- CLEAR: drive `slv_rst_n`=0 for exactly 2 cycles. Then go to STREAM, or to DRAIN if the count is 0.
- STREAM: while `pause`=0 and issued<count, assert `mem_rd_en` with `mem_addr` = issued index, starting at 0 and incrementing by 1.
- Each read's `mem_rd_data` is forwarded the following cycle as `slv_read_val`, with `slv_read_val_valid`=1. This path is a registered valid pipe and is not affected by `pause`.
- Leave STREAM when the last byte has been delivered to the solver, not merely issued.
- DRAIN: count `DRAIN_CYCLES` idle cycles, then go to DONE.
- DONE: assert `slv_read_val_done` for 1 cycle, then go to WAIT.
- WAIT: on the first cycle `slv_output_data_valid`=1, register `slv_output_data` into `result`, set `result_valid`, and go to IDLE.
- `start` outside IDLE is ignored. `pause` outside STREAM has no effect.
- Address arithmetic: issued counter is ADDR_W+1 bits; `mem_addr` is its low ADDR_W bits. Count 2^ADDR_W is legal and reads addresses 0..2^ADDR_W−1 with no wrap beyond.

## Timing
- Reset (async assert, sync deassert by the surrounding reset tree), all outputs 0 except `slv_rst_n`:
  - state = IDLE
  - `busy`, `mem_rd_en`, `slv_read_val_valid`, `slv_read_val_done`, `result_valid`, `error` = 0
  - `result` and `slv_read_val` = 0
  - `slv_rst_n` = 0 while `rst_n` is low, 1 after.
- Reset mid-run aborts immediately; no `slv_read_val_done` is issued.
- `start` accepted at edge T:
  - `slv_rst_n` low at T+1 and T+2.
  - First `mem_rd_en` at T+3.
  - First `slv_read_val_valid` at T+4.
- With `pause`=0, N bytes occupy N consecutive valid cycles, T+4..T+N+3.
- `slv_read_val_done` is asserted at cycle T+N+4+DRAIN_CYCLES.
- `pause` asserted in cycle P:
  - No read is issued in P.
  - A read issued in P−1 still delivers in P.
  - Resume is seamless on the cycle `pause` drops.
- Capture: `result_valid` rises 1 cycle after `slv_output_data_valid` is sampled high.

## Configuration
- `D3_RUN_TIMEOUT_EN` defined:
  - WAIT counts cycles; at `TIMEOUT_CYCLES` with no valid, go to ERROR.
  - ERROR sets `error`=1 and `result_valid`=1 with `result`=0, then returns to IDLE next cycle.
- `D3_RUN_TIMEOUT_EN` undefined:
  - No counter and no ERROR state; WAIT waits indefinitely.
  - `error` is tied 0.

## Structure
- `d3_pkg` holds:
  - the `d3_run_state_e` enum
  - `D3_BYTE_W`=8 and `D3_RESULT_W`=64
  - the default `DRAIN_CYCLES`/`TIMEOUT_CYCLES` localparams.
- One sub-module: `d3_rd_pipe`, the 1-deep read-issue/valid-forward pipe that converts `mem_rd_en` into `slv_read_val_valid`.
- FSM and counters stay in `d3_run_ctrl`.

## Test plan
- Memory holds "mul(2,4)" (8 bytes), start with count 8, real solver attached → 8 consecutive valid bytes from T+4, done at T+16, `result`=8, `result_valid`=1.
- "xmul(2,4)don't()mul(5,5)do()mul(3,3)" → `result`=17; no gaps in `slv_read_val_valid`.
- Count 8 with `pause` high for cycles T+5..T+7 → bytes delivered in order with a 3-cycle gap, no byte lost or duplicated, result still 8.
- Count 0 → no `mem_rd_en`; done at T+3+DRAIN_CYCLES; `result`=0.
- `start` pulsed mid-STREAM → ignored; `rst_n` pulsed mid-STREAM → all outputs at reset values the same cycle; no done pulse.
- With `D3_RUN_TIMEOUT_EN`, solver stub never asserts valid → `error`=1 and `result_valid`=1 exactly `TIMEOUT_CYCLES`+1 cycles after done, then back in IDLE.

Source files
------------

// File: rtl/d3_pkg.sv
// ============================================================================
// Module      : d3_pkg
// Description : Shared types and constants for the day-3 run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package d3_pkg;

    localparam int D3_BYTE_W          = 8;
    localparam int D3_RESULT_W        = 64;
    localparam int D3_DRAIN_CYCLES    = 4;
    localparam int D3_TIMEOUT_CYCLES  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_WAIT   = 3'd5
`ifdef D3_RUN_TIMEOUT_EN
        ,
        ST_ERROR  = 3'd6
`endif
    } d3_run_state_e;

endpackage

`default_nettype wire

// File: rtl/d3_rd_pipe.sv
// ============================================================================
// Module      : d3_rd_pipe
// Description : One-deep pipe turning a memory read strobe into a byte valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d3_rd_pipe
    import d3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [D3_BYTE_W-1:0] rd_data,
    output logic                 val_valid,
    output logic [D3_BYTE_W-1:0] val
);

    logic r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_en;
        end
    end

    // Memory data is already one cycle late; gate it so idle cycles read as zero.
    assign val_valid = r_valid;
    assign val       = r_valid ? rd_data : '0;

endmodule

`default_nettype wire

// File: rtl/d3_run_ctrl.sv
// ============================================================================
// Module      : d3_run_ctrl
// Description : Run controller: clears the solver, streams input bytes, drains,
//               signals end-of-input and captures the 64-bit total.
//               Optional macro D3_RUN_TIMEOUT_EN adds a result-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d3_run_ctrl
    import d3_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DRAIN_CYCLES   = D3_DRAIN_CYCLES,
    parameter int TIMEOUT_CYCLES = D3_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W:0]        byte_count,
    input  logic                   pause,
    output logic                   busy,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [D3_BYTE_W-1:0]   mem_rd_data,
    output logic                   slv_rst_n,
    output logic [D3_BYTE_W-1:0]   slv_read_val,
    output logic                   slv_read_val_valid,
    output logic                   slv_read_val_done,
    input  logic [D3_RESULT_W-1:0] slv_output_data,
    input  logic                   slv_output_data_valid,
    output logic [D3_RESULT_W-1:0] result,
    output logic                   result_valid,
    output logic                   error
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W:0] ISSUE_ONE = {{ADDR_W{1'b0}}, 1'b1};

    if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("d3_run_ctrl: DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    d3_run_state_e          r_state;
    logic [ADDR_W:0]        r_count;
    logic [ADDR_W:0]        r_issued;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [D3_RESULT_W-1:0] r_result;
    logic                   r_result_valid;
    logic                   w_rd_en;

`ifdef D3_RUN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_wait;
    logic            r_error;
`endif

    // Read issue must react to pause in the same cycle, so it is decoded, not registered.
    assign w_rd_en = (r_state == ST_STREAM) && !pause && (r_issued < r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_issued       <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
`ifdef D3_RUN_TIMEOUT_EN
            r_wait         <= '0;
            r_error        <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count        <= byte_count;
                        r_issued       <= '0;
                        r_cnt          <= '0;
                        r_result       <= '0;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b1;
`ifdef D3_RUN_TIMEOUT_EN
                        r_error        <= 1'b0;
`endif
                        r_state        <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= (r_count == '0) ? ST_DRAIN : ST_STREAM;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + ISSUE_ONE;
                    end
                    // All issued implies the final read is being delivered this cycle.
                    if (r_issued == r_count) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
`ifdef D3_RUN_TIMEOUT_EN
                    r_wait  <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (slv_output_data_valid) begin
                        r_result       <= slv_output_data;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
`ifdef D3_RUN_TIMEOUT_EN
                    else if (r_wait == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_result       <= '0;
                        r_result_valid <= 1'b1;
                        r_error        <= 1'b1;
                        r_state        <= ST_ERROR;
                    end else begin
                        r_wait <= r_wait + TO_W'(1);
                    end
`endif
                end
`ifdef D3_RUN_TIMEOUT_EN
                ST_ERROR: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    d3_rd_pipe u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (w_rd_en),
        .rd_data   (mem_rd_data),
        .val_valid (slv_read_val_valid),
        .val       (slv_read_val)
    );

    assign busy              = r_busy;
    assign mem_rd_en         = w_rd_en;
    assign mem_addr          = r_issued[ADDR_W-1:0];
    assign slv_rst_n         = rst_n && (r_state != ST_CLEAR);
    assign slv_read_val_done = r_done;
    assign result            = r_result;
    assign result_valid      = r_result_valid;
`ifdef D3_RUN_TIMEOUT_EN
    assign error             = r_error;
`else
    assign error             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d3_run_ctrl.sv
// ============================================================================
// Module      : tb_d3_run_ctrl
// Description : Directed, table-driven bench for d3_run_ctrl with a solver stub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d3_run_ctrl;

    localparam int AW = 6;
    localparam int DR = 4;
    localparam int TO = 16;
    localparam int MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   byte_count;
    logic          pause;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          slv_rst_n;
    logic [7:0]    slv_read_val;
    logic          slv_read_val_valid;
    logic          slv_read_val_done;
    logic [63:0]   slv_output_data;
    logic          slv_output_data_valid;
    logic [63:0]   result;
    logic          result_valid;
    logic          error;

    always #5 clk = ~clk;

    d3_run_ctrl #(
        .ADDR_W         (AW),
        .DRAIN_CYCLES   (DR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .byte_count            (byte_count),
        .pause                 (pause),
        .busy                  (busy),
        .mem_rd_en             (mem_rd_en),
        .mem_addr              (mem_addr),
        .mem_rd_data           (mem_rd_data),
        .slv_rst_n             (slv_rst_n),
        .slv_read_val          (slv_read_val),
        .slv_read_val_valid    (slv_read_val_valid),
        .slv_read_val_done     (slv_read_val_done),
        .slv_output_data       (slv_output_data),
        .slv_output_data_valid (slv_output_data_valid),
        .result                (result),
        .result_valid          (result_valid),
        .error                 (error)
    );

    // 1-cycle-latency input memory
    logic [7:0] mem [0:MEM_N-1];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Solver stub: position-weighted byte sum, answered 3 cycles after done
    logic [63:0] acc = '0;
    int          sidx = 0;
    logic [2:0]  sh = 3'b000;
    logic        mute = 1'b0;
    always @(posedge clk) begin
        if (!slv_rst_n) begin
            acc  <= '0;
            sidx <= 0;
        end else if (slv_read_val_valid) begin
            acc  <= acc + 64'(slv_read_val) * 64'(sidx + 1);
            sidx <= sidx + 1;
        end
        sh <= {sh[1:0], slv_read_val_done};
    end
    assign slv_output_data_valid = sh[2] & ~mute;
    assign slv_output_data       = acc;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cnt;     // bytes to stream
        int pf;      // first paused cycle (relative to start edge)
        int pl;      // paused cycles
        int sk;      // cycle of a stray start pulse, 0 = none
        int fv;      // expected first valid cycle, -1 = none
        int done_k;  // expected done cycle
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        logic [63:0] exp_sum = '0;
        int iss = 0, del = 0, fv = -1, done_k = -1, done_n = 0, rv_k = -1;
        bit ord_ok = 1'b1, addr_ok = 1'b1;
        for (int i = 0; i < v.cnt; i++) exp_sum += 64'(mem[i]) * 64'(i + 1);
        byte_count = (AW + 1)'(v.cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 200; k++) begin
            pause = (v.pl > 0) && (k >= v.pf) && (k < v.pf + v.pl);
            start = (k == v.sk);
            if (k == v.sk) byte_count = (AW + 1)'(3);
            @(negedge clk);
            if (k <= 3) chk($sformatf("v%0d slv_rst_n k%0d", id, k), 64'(slv_rst_n), 64'(k > 2));
            if (k == 1) begin
                chk($sformatf("v%0d busy", id), 64'(busy), 64'(1));
                chk($sformatf("v%0d rv_cleared", id), 64'(result_valid), 64'(0));
            end
            if (mem_rd_en) begin
                if (mem_addr != AW'(iss)) addr_ok = 1'b0;
                iss++;
            end
            if (slv_read_val_valid) begin
                if (fv < 0) fv = k;
                if (del >= MEM_N || slv_read_val != mem[del]) ord_ok = 1'b0;
                del++;
            end
            if (slv_read_val_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (result_valid) begin
                rv_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        pause = 1'b0;
        chk($sformatf("v%0d reads", id), 64'(iss), 64'(v.cnt));
        chk($sformatf("v%0d bytes", id), 64'(del), 64'(v.cnt));
        chk($sformatf("v%0d addr_seq", id), 64'(addr_ok), 64'(1));
        chk($sformatf("v%0d byte_order", id), 64'(ord_ok), 64'(1));
        chk($sformatf("v%0d first_valid", id), 64'(fv), 64'(v.fv));
        chk($sformatf("v%0d done_cycle", id), 64'(done_k), 64'(v.done_k));
        chk($sformatf("v%0d done_pulses", id), 64'(done_n), 64'(1));
        chk($sformatf("v%0d rv_cycle", id), 64'(rv_k), 64'(v.done_k + 4));
        chk($sformatf("v%0d result", id), result, exp_sum);
        chk($sformatf("v%0d error", id), 64'(error), 64'(0));
        chk($sformatf("v%0d idle", id), 64'(busy), 64'(0));
    endtask

    vec_t vecs[9];

    initial begin
        string s;
        int    cyc;
        bit    seen;
        s = "xmul(2,4)don't()mul(5,5)do()mul(3,3)";
        for (int i = 0; i < MEM_N; i++) mem[i] = (i < s.len()) ? s[i] : 8'(i * 7 + 3);

        vecs[0] = '{8,  0,  0, 0,  4, 16};
        vecs[1] = '{36, 0,  0, 0,  4, 44};
        vecs[2] = '{8,  5,  3, 0,  4, 19};
        vecs[3] = '{0,  0,  0, 0, -1,  7};
        vecs[4] = '{8,  0,  0, 6,  4, 16};
        vecs[5] = '{64, 0,  0, 0,  4, 72};
        vecs[6] = '{1,  3,  2, 0,  6, 11};
        vecs[7] = '{8,  1,  2, 0,  4, 16};
        vecs[8] = '{8,  13, 2, 0,  4, 16};

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; byte_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst slv_rst_n", 64'(slv_rst_n), 64'(0));
        chk("rst result", result, 64'(0));
        chk("rst outputs", {59'(0), mem_rd_en, slv_read_val_valid, slv_read_val_done, result_valid, error}, 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst slv_rst_n", 64'(slv_rst_n), 64'(1));

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of streaming
        byte_count = (AW + 1)'(8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst streaming", 64'(mem_rd_en), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst rd_en", 64'(mem_rd_en), 64'(0));
        chk("midrst valid", {62'(0), slv_read_val_valid, slv_read_val_done}, 64'(0));
        chk("midrst val", 64'(slv_read_val), 64'(0));
        chk("midrst slv_rst_n", 64'(slv_rst_n), 64'(0));
        chk("midrst result", {result[62:0], result_valid}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (slv_read_val_done || busy) seen = 1'b1;
        end
        chk("midrst no done", 64'(seen), 64'(0));
        @(posedge clk); #1;
        run_vec(vecs[0], 9);

`ifdef D3_RUN_TIMEOUT_EN
        // Solver never answers: done at cycle 10, error at 10+TO+1
        mute = 1'b1;
        byte_count = (AW + 1)'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (error) begin
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("to error_cycle", 64'(cyc), 64'(2 + 8 + TO + 1));
        chk("to result_valid", 64'(result_valid), 64'(1));
        chk("to result", result, 64'(0));
        @(posedge clk); #1;
        chk("to idle", 64'(busy), 64'(0));
        mute = 1'b0;
`else
        cyc = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
